// File: rtl/sfu_multimode_engine.sv
// rtl/sfu_multimode_engine.sv - multi-mode special-function unit walking PSUM rows in place
module sfu_multimode_engine #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W  = 11,
  parameter int FRAC    = 8,
  parameter int SUM_BW  = PSUM_BW + $clog2(COL)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_sfu,
  input  logic [1:0]                 cfg_mode,
  input  logic [ADDR_W-1:0]          cfg_base,
  input  logic [ADDR_W-1:0]          cfg_rows,
  input  logic [$clog2(PSUM_BW)-1:0] cfg_shift,
  input  logic [COL*PSUM_BW-1:0]     sfu_in,
  output logic [COL*PSUM_BW-1:0]     sfu_out,
  output logic [ADDR_W-1:0]          psum_mem_addr,
  output logic                       psum_mem_rd_enable,
  output logic                       psum_mem_wr_enable,
  output logic                       sfu_active,
  output logic                       sfu_done
);

  localparam int SH_W  = $clog2(PSUM_BW);
  localparam int NUM_W = PSUM_BW + FRAC;
  localparam int DIV_W = (NUM_W > SUM_BW) ? NUM_W : SUM_BW;

  localparam logic [1:0] MODE_RELU  = 2'b00;
  localparam logic [1:0] MODE_ABS   = 2'b01;
  localparam logic [1:0] MODE_NORM  = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  localparam logic [PSUM_BW-1:0] LANE_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CALC,
    S_WR,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]             mode_q;
  logic [SH_W-1:0]        shift_q;
  logic [ADDR_W-1:0]      rows_q;
  logic [ADDR_W-1:0]      row_cnt;
  logic [COL*PSUM_BW-1:0] row_q;
  logic                   last_row;

  logic signed [PSUM_BW-1:0] lane_x [COL];
  logic        [PSUM_BW-1:0] mag    [COL];
  logic [SUM_BW-1:0]         abs_sum;
  logic [COL*PSUM_BW-1:0]    calc_row;

  assign last_row = ((row_cnt + ADDR_W'(1)) == rows_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_sfu) begin
          state_nxt = (cfg_rows == '0) ? S_DONE : S_RD;
        end
      end
      S_RD:   state_nxt = S_WAIT;
      S_WAIT: state_nxt = S_CALC;
      S_CALC: state_nxt = S_WR;
      S_WR:   state_nxt = last_row ? S_DONE : S_RD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    psum_mem_rd_enable = (state == S_RD);
    psum_mem_wr_enable = (state == S_WR);
    sfu_active         = (state == S_RD) || (state == S_WAIT) ||
                         (state == S_CALC) || (state == S_WR);
    sfu_done           = (state == S_DONE);
  end

  // Config is frozen at start; the address register doubles as the row pointer for read and write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q        <= '0;
      shift_q       <= '0;
      rows_q        <= '0;
      row_cnt       <= '0;
      row_q         <= '0;
      sfu_out       <= '0;
      psum_mem_addr <= '0;
    end else begin
      if ((state == S_IDLE) && start_sfu) begin
        mode_q        <= cfg_mode;
        shift_q       <= cfg_shift;
        rows_q        <= cfg_rows;
        row_cnt       <= '0;
        psum_mem_addr <= cfg_base;
      end
      if (state == S_WAIT) begin
        row_q <= sfu_in;
      end
      if (state == S_CALC) begin
        sfu_out <= calc_row;
      end
      if (state == S_WR) begin
        psum_mem_addr <= psum_mem_addr + ADDR_W'(1);
        row_cnt       <= row_cnt + ADDR_W'(1);
      end
    end
  end

  // Unsaturated magnitudes: the most negative value maps to 2^(PSUM_BW-1), which fits unsigned.
  always_comb begin
    abs_sum = '0;
    for (int i = 0; i < COL; i++) begin
      lane_x[i] = row_q[i*PSUM_BW +: PSUM_BW];
      mag[i]    = lane_x[i][PSUM_BW-1] ? PSUM_BW'(-lane_x[i]) : lane_x[i];
      abs_sum   = abs_sum + SUM_BW'(mag[i]);
    end
  end

  // Quotients never exceed 2^FRAC since each |x_i| <= S, so truncation to PSUM_BW is lossless.
  always_comb begin
    calc_row = '0;
    for (int i = 0; i < COL; i++) begin
      case (mode_q)
        MODE_RELU: begin
          calc_row[i*PSUM_BW +: PSUM_BW] = lane_x[i][PSUM_BW-1] ? '0 : lane_x[i];
        end
        MODE_ABS: begin
          calc_row[i*PSUM_BW +: PSUM_BW] = mag[i][PSUM_BW-1] ? LANE_MAX : mag[i];
        end
        MODE_NORM: begin
          if (abs_sum != '0) begin
            calc_row[i*PSUM_BW +: PSUM_BW] =
              PSUM_BW'((DIV_W'(mag[i]) << FRAC) / DIV_W'(abs_sum));
          end
        end
        MODE_SHIFT: begin
          calc_row[i*PSUM_BW +: PSUM_BW] = lane_x[i] >>> shift_q;
        end
        default: calc_row[i*PSUM_BW +: PSUM_BW] = '0;
      endcase
    end
  end

endmodule

// File: doc/sfu_multimode_engine.md
# sfu_multimode_engine

Parametrised special-function unit for the attention datapath. It sits between the PSUM memory and the next stage. On a start pulse it walks a programmable range of PSUM rows, applies one of four per-lane functions to each row, and writes the result back in place: ReLU, saturating absolute value, row-wise L1 normalisation, or arithmetic right shift. It generalises the fixed single-function SFU array to a configurable row count, base address and mode, and adds a done pulse.

## Interface
- `COL`, 8, number of lanes per PSUM row
- `PSUM_BW`, 16, signed lane width
- `ADDR_W`, 11, PSUM memory address width
- `FRAC`, 8, fraction bits of the normalised output; legal range 1..PSUM_BW-2
- `SUM_BW`, PSUM_BW+$clog2(COL), width of the row abs-sum accumulator

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start_sfu`  in  1  one-cycle start request; ignored unless idle
- `cfg_mode`  in  2  function select: 00 ReLU, 01 ABS, 10 NORM, 11 SHIFT
- `cfg_base`  in  ADDR_W  first row address
- `cfg_rows`  in  ADDR_W  number of rows to process
- `cfg_shift`  in  $clog2(PSUM_BW)  shift amount for SHIFT mode
- `sfu_in`  in  COL*PSUM_BW  signed row read from PSUM memory; lane i at bits [i*PSUM_BW +: PSUM_BW]
- `sfu_out`  out  COL*PSUM_BW  registered result row (write data)
- `psum_mem_addr`  out  ADDR_W  read/write address
- `psum_mem_rd_enable`  out  1  read strobe
- `psum_mem_wr_enable`  out  1  write strobe
- `sfu_active`  out  1  high while rows are being processed
- `sfu_done`  out  1  one-cycle completion pulse

## Operation
- All `cfg_*` inputs are latched in the cycle `start_sfu` is sampled high in IDLE. Later changes to them have no effect until the next start.
- FSM states: IDLE, RD, WAIT, CALC, WR, DONE.
  - IDLE→RD on start when cfg_rows≠0.
  - IDLE→DONE on start when cfg_rows=0.
  - RD→WAIT→CALC→WR.
  - WR→RD if rows remain, otherwise WR→DONE.
  - DONE→IDLE.
- A row counter and an address register start at base. Both advance after each WR.
  - Address increments modulo 2^ADDR_W, so wrap-around is legal.
  - The same address is used for the read and the write of a row (in-place).
- Memory read latency is one cycle: `sfu_in` is valid in the cycle after `psum_mem_rd_enable`. `sfu_in` is captured into a row register at the end of WAIT.
- CALC computes all lanes from the row register and registers the result into `sfu_out`.
  - ReLU: x<0 → 0, else x.
  - ABS: |x|, with -2^(PSUM_BW-1) saturating to 2^(PSUM_BW-1)-1.
  - NORM:
    - S = Σ|x_j| over all lanes, SUM_BW bits, using unsaturated magnitudes.
    - out_i = floor((|x_i|·2^FRAC)/S), unsigned, zero-extended.
    - S=0 → all lanes 0. The result always fits because |x_i| ≤ S.
  - SHIFT: x >>> cfg_shift (arithmetic).
- `start_sfu` while not IDLE is ignored. It is not queued.

## Timing
- Reset values: `sfu_out`=0, `psum_mem_addr`=0, both enables 0, `sfu_active`=0, `sfu_done`=0, FSM in IDLE, all counters 0.
- Reset asserted mid-operation returns the block to IDLE on that edge.
  - No further read or write is issued.
  - No done pulse is produced.
  - A row already in flight is discarded.
- Cycle numbering: cycle 0 is the cycle in which `start_sfu` is sampled high.
- Row r (0-based) occupies cycles 4r+1..4r+4:
  - RD: rd_enable=1, addr=base+r
  - WAIT: memory drives data
  - CALC: no strobes
  - WR: wr_enable=1, addr=base+r, `sfu_out`=result
- `sfu_active` is high in cycles 1..4N, with N=cfg_rows.
- `sfu_done` is high in cycle 4N+1 only. IDLE is re-entered in cycle 4N+2, so the earliest new start is sampled in cycle 4N+2.
- N=0: `sfu_done` is high in cycle 1. No strobes, `sfu_active` stays 0.
- The read and write strobes are never high in the same cycle.
- `sfu_out` holds its value outside WR until the next CALC.
- `psum_mem_addr` holds its last value when idle.

## Test plan
- Reset and idle: hold reset 2 cycles with start high.
  - All outputs stay at reset values.
  - No strobe appears.
- ReLU, 1 row, base 5: memory returns lanes 7..0 = {12,-5,7,-2,10,280,0,-15}.
  - Write in cycle 4 at addr 5 of {12,0,7,0,10,280,0,0}.
  - done in cycle 5.
- NORM, FRAC=8: same row (S=331).
  - Lane 2 = 216, lane 7 = 9, lane 0 = 11, lane 1 = 0.
  - An all-zero row yields all zeros.
- SHIFT=2 and ABS:
  - SHIFT gives lane 0 = -4, lane 2 = 70, lane 6 = -2.
  - ABS on lane -32768 gives 32767.
- Multi-row with wrap: base 2046 (ADDR_W=11), rows 3.
  - Addresses are 2046, 2047, 0.
  - `sfu_active` lasts 12 cycles; done in cycle 13.
  - A start pulse at cycle 6 is ignored.
  - cfg_rows=0 gives done in cycle 1 with no strobes.
- Reset mid-run: assert reset in cycle 7 of a 3-row job.
  - Only row 0 is written.
  - Outputs return to reset values; no done pulse.
  - A new start then runs normally.
